lsu_align_ctrl: RTL and testbench
=================================

# lsu_align_ctrl

Load/store alignment controller between the execute stage and `data_mem`. It accepts one load or store request at a time from the core and performs all byte-lane work itself. It splits accesses that straddle a 32-bit word boundary into two aligned word accesses, merging stores by read-modify-write and assembling loads before sign or zero extension. `data_mem` is only ever driven with aligned word accesses (`funct3 = 3'b010`). Its own sub-word lane logic is bypassed.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: data word width. Only 32 is supported.
- `ADDR_WIDTH`, 32: byte-address width.

**Ports**
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: core request present.
- `req_ready`, out, 1: the controller can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_funct3`, in, 3: RISC-V load/store `funct3`.
- `req_addr`, in, `ADDR_WIDTH`: byte address.
- `req_wdata`, in, `DATA_WIDTH`: store data, right-aligned.
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rsp_err`, out, 1: illegal `funct3`. Valid only with `rsp_valid`.
- `rsp_rdata`, out, `DATA_WIDTH`: load result. 0 for stores and errors.
- `mem_wr_en`, out, 1: to `data_mem.wr_en`.
- `mem_funct3`, out, 3: constant `3'b010`.
- `mem_addr`, out, `ADDR_WIDTH`: word-aligned address, with bits [1:0] = 0.
- `mem_wr_data`, out, `DATA_WIDTH`: merged store word.
- `mem_rd_data`, in, `DATA_WIDTH`: from `data_mem.rd_data_mem`. Combinational read of `mem_addr`.

## Operation

**States**
- `IDLE`, `ACC0`, `ACC1`, `RESP`.
- `req_ready = (state == IDLE) && !reset`.

**IDLE**
- On `req_valid && req_ready`, capture `we`, `funct3`, `addr` and `wdata`.
- Compute `off = addr[1:0]` and `size`: 1 for `funct3` 000/100, 2 for 001/101, 4 for 010.
- Illegal `funct3` (011, 110, 111): go to `RESP` with `err = 1`. No memory access.
- Legal `funct3`: go to `ACC0`.
- `split = (off + size > 4)`.

**ACC0**
- `mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}`.
- Register `mem_rd_data` as `w0`.
- Store: `mem_wr_en = 1`. `mem_wr_data` is `mem_rd_data` with lanes in `bmask[3:0]` replaced by `sdata[31:0]`.
  - `bmask = ((1 << size) - 1) << off`, 8 bits.
  - `sdata = {32'b0, wdata} << (8*off)`, 64 bits.
- Next state is `ACC1` if `split`, else `RESP`.

**ACC1**
- `mem_addr = word address of ACC0 + 4`, wrapping modulo 2^`ADDR_WIDTH`.
- Register `mem_rd_data` as `w1`.
- Store: `mem_wr_en = 1`. Lanes `bmask[7:4]` are replaced by `sdata[63:32]`.
- Next state is `RESP`.

**RESP**
- `rsp_valid = 1` for exactly this one cycle. Next state is `IDLE`.

**Load assembly** (registered on entry to `RESP`)
- `raw = {w1, w0} >> (8*off)`. `w1` is treated as 0 when the access is not split.
- `rsp_rdata` is `raw` truncated to `size` bytes.
  - Sign-extended for `funct3` 000 and 001.
  - Zero-extended for 100 and 101.
  - `funct3` 010 is the full word.
- Byte order is little-endian.

**Output values**
- `mem_wr_en = 0` in `IDLE` and `RESP`, for loads, and while `reset` is high.
- `rsp_rdata` and `rsp_err` hold their value until the next `RESP`.

**Reset**
- All outputs read 0 while `reset` is high, except `mem_funct3`. `req_ready` is 0 during reset and 1 in the first cycle after it.
- Registers clear to 0 and state goes to `IDLE`.
- Reset in `ACC1` or `RESP` drops the request with no `rsp_valid`. A word already written in `ACC0` stays written.

## Timing

- Request accepted at edge T, i.e. the cycle in which `req_valid && req_ready` is sampled.
- Non-split access: memory cycle T+1, `rsp_valid` at T+2.
- Split access: memory cycles T+1 and T+2, `rsp_valid` at T+3.
- Illegal `funct3`: `rsp_valid` at T+1.
- `req_ready` is low from T+1 until `RESP` ends, so the next accept is at T+3 (non-split) or T+4 (split) at the earliest.
- `req_*` inputs are ignored when not accepted. The request does not need to be held after acceptance.
- A store write lands at the rising edge that ends `ACC0`/`ACC1`. The read and merge are combinational within the same cycle.

## Test plan

1. Preload `mem[0x10] = 0x44332211` and `mem[0x14] = 0x88776655`. LW `0x10` -> `rsp_valid` 2 cycles after accept, `rsp_rdata = 0x44332211`, `rsp_err = 0`.
2. LB `0x13` -> `0x00000044`. LB `0x17` -> `0xFFFFFF88`. LBU `0x17` -> `0x00000088`. All non-split, 2-cycle latency.
3. LHU `0x13` (split) -> `mem_addr` is `0x10` then `0x14`, `rsp_rdata = 0x00005544`, `rsp_valid` 3 cycles after accept.
4. SW `0xAABBCCDD` to `0x11` (split) -> `mem[0x10] = 0xBBCCDD11`, `mem[0x14] = 0x887766AA`. A following LW `0x12` -> `0x66AABBCC`.
5. `req_funct3 = 3'b011` -> `rsp_valid` and `rsp_err = 1` one cycle after accept, `rsp_rdata = 0`, `mem_wr_en` never asserted.
6. SW to `0x11` with `reset` asserted during `ACC1` -> `mem[0x10]` updated, `mem[0x14]` unchanged, no `rsp_valid`, `req_ready = 1` in the first cycle after reset drops.

Source files
------------

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: splits word-straddling accesses into two aligned
// word accesses, merges stores by read-modify-write and assembles/extends loads.
module lsu_align_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                  state_reg, state_next;
  logic                    we_reg;
  logic [2:0]              funct3_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   w0_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    err_reg;

  logic [2:0]              size;
  logic [1:0]              off;
  logic                    split;
  logic [7:0]              bmask_base;
  logic [7:0]              bmask;
  logic [2*DATA_WIDTH-1:0] sdata;
  logic [DATA_WIDTH-1:0]   hi_word;
  logic [DATA_WIDTH-1:0]   lo_word;
  logic [DATA_WIDTH-1:0]   raw;
  logic [DATA_WIDTH-1:0]   load_data;
  logic [DATA_WIDTH-1:0]   merged;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    req_illegal;

  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
  assign off         = addr_reg[1:0];
  assign word_addr   = {addr_reg[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    size       = 3'd4;
    bmask_base = 8'h0F;
    case (funct3_reg[1:0])
      2'b00:   begin size = 3'd1; bmask_base = 8'h01; end
      2'b01:   begin size = 3'd2; bmask_base = 8'h03; end
      default: begin size = 3'd4; bmask_base = 8'h0F; end
    endcase
  end

  assign split = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign bmask = bmask_base << off;
  assign sdata = {{DATA_WIDTH{1'b0}}, wdata_reg} << {off, 3'b000};

  // The second word only exists in ACC1; a non-split load assembles from ACC0 alone.
  assign hi_word = (state_reg == ACC1) ? mem_rd_data : '0;
  assign lo_word = (state_reg == ACC1) ? w0_reg : mem_rd_data;
  assign raw     = DATA_WIDTH'({hi_word, lo_word} >> {off, 3'b000});

  always_comb begin
    load_data = raw;
    case (funct3_reg)
      3'b000:  load_data = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
      default: load_data = raw;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = (state_reg == ACC1)
          ? (bmask[4+gi] ? sdata[DATA_WIDTH+8*gi +: 8] : mem_rd_data[8*gi +: 8])
          : (bmask[gi]   ? sdata[8*gi +: 8]            : mem_rd_data[8*gi +: 8]);
    end
  endgenerate

  assign mem_funct3 = 3'b010;
  assign rsp_rdata  = reset ? '0 : rdata_reg;
  assign rsp_err    = reset ? 1'b0 : err_reg;

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_illegal ? RESP : ACC0;
      end
      ACC0: begin
        mem_addr    = word_addr;
        mem_wr_en   = we_reg;
        mem_wr_data = we_reg ? merged : '0;
        state_next  = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_addr    = word_addr + ADDR_WIDTH'(4);
        mem_wr_en   = we_reg;
        mem_wr_data = we_reg ? merged : '0;
        state_next  = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs are forced quiet while reset is held, even mid-access.
    if (reset) begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      w0_reg     <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            if (req_illegal) begin
              err_reg   <= 1'b1;
              rdata_reg <= '0;
            end
          end
        end
        ACC0: begin
          w0_reg <= mem_rd_data;
          if (!split) begin
            err_reg   <= 1'b0;
            rdata_reg <= we_reg ? '0 : load_data;
          end
        end
        ACC1: begin
          err_reg   <= 1'b0;
          rdata_reg <= we_reg ? '0 : load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed bench for lsu_align_ctrl with a word-addressed memory model and a
// scoreboard queue of expected responses.
module tb_lsu_align_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  lsu_align_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // 16-word memory; address bits [5:2] select the word, so 0xFFFFFFFC aliases word 15.
  logic [31:0] mem [0:15];
  assign mem_rd_data = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wr_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] addr_log[$];
  logic        wr_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    logic got;
    exp_q.push_back('{exp_rd, exp_err, exp_lat, name});
    addr_log.delete();
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    lat = 1; got = 1'b0; wr_seen = 1'b0;
    while (lat <= 6) begin
      if (mem_wr_en) wr_seen = 1'b1;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      addr_log.push_back(mem_addr);
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check({e.name, " responded"}, 32'(got), 32'd1);
    check({e.name, " latency"}, 32'(lat), 32'(e.lat));
    check({e.name, " rsp_err"}, 32'(rsp_err), 32'(e.err));
    check({e.name, " rsp_rdata"}, rsp_rdata, e.rdata);
    $display("txn %-10s we=%0d f3=%b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             e.name, we, f3, a, wd, rsp_rdata, rsp_err, lat);
    @(negedge clk);
    check({e.name, " rdata hold"}, rsp_rdata, e.rdata);
    check({e.name, " rsp_valid one cycle"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    mem[0]  <= 32'h12345678;
    mem[4]  <= 32'h44332211;
    mem[5]  <= 32'h88776655;
    mem[15] <= 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("reset mem_funct3", 32'(mem_funct3), 32'd2);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    #1;
    check("post-reset req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    do_req("LW 10",   1'b0, 3'b010, 32'h10, 32'h0, 32'h44332211, 1'b0, 2);
    do_req("LB 13",   1'b0, 3'b000, 32'h13, 32'h0, 32'h00000044, 1'b0, 2);
    do_req("LB 17",   1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFFFF88, 1'b0, 2);
    do_req("LBU 17",  1'b0, 3'b100, 32'h17, 32'h0, 32'h00000088, 1'b0, 2);

    do_req("LHU 13",  1'b0, 3'b101, 32'h13, 32'h0, 32'h00005544, 1'b0, 3);
    check("LHU 13 mem cycles", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check("LHU 13 addr0", addr_log[0], 32'h10);
      check("LHU 13 addr1", addr_log[1], 32'h14);
    end

    do_req("SW 11",   1'b1, 3'b010, 32'h11, 32'hAABBCCDD, 32'h0, 1'b0, 3);
    check("SW 11 write seen", 32'(wr_seen), 32'd1);
    check("SW 11 mem[10]", mem[4], 32'hBBCCDD11);
    check("SW 11 mem[14]", mem[5], 32'h887766AA);
    do_req("LW 12",   1'b0, 3'b010, 32'h12, 32'h0, 32'h66AABBCC, 1'b0, 3);
    do_req("LH 16",   1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8877, 1'b0, 2);

    do_req("LHU wrap", 1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 32'h000078DE, 1'b0, 3);
    check("LHU wrap mem cycles", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check("LHU wrap addr0", addr_log[0], 32'hFFFFFFFC);
      check("LHU wrap addr1", addr_log[1], 32'h00000000);
    end

    do_req("ILL 011", 1'b1, 3'b011, 32'h10, 32'h55555555, 32'h0, 1'b1, 1);
    check("ILL 011 no write", 32'(wr_seen), 32'd0);
    do_req("SB 1F",   1'b1, 3'b000, 32'h1F, 32'h000000C3, 32'h0, 1'b0, 2);
    check("SB 1F mem[1C]", mem[7], 32'hC3000000);
    do_req("ILL 110", 1'b0, 3'b110, 32'h14, 32'h0, 32'h0, 1'b1, 1);
    check("mem[14] untouched", mem[5], 32'h887766AA);

    // Split store interrupted by reset during its second word access.
    check("SW rst req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h11; req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("SW rst acc0 wr_en", 32'(mem_wr_en), 32'd1);
    check("SW rst acc0 addr", mem_addr, 32'h10);
    @(negedge clk);
    check("SW rst acc1 wr_en", 32'(mem_wr_en), 32'd1);
    check("SW rst acc1 addr", mem_addr, 32'h14);
    reset = 1'b1;
    #1;
    check("SW rst wr_en gated", 32'(mem_wr_en), 32'd0);
    check("SW rst rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("SW rst rsp_valid held", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("SW rst req_ready after", 32'(req_ready), 32'd1);
    check("SW rst rsp_valid after", 32'(rsp_valid), 32'd0);
    check("SW rst rsp_rdata cleared", rsp_rdata, 32'h0);
    check("SW rst mem[10]", mem[4], 32'h22334411);
    check("SW rst mem[14]", mem[5], 32'h887766AA);
    $display("txn SW rst    we=1 f3=010 addr=00000011 wdata=11223344 -> reset in ACC1, mem[10]=%h mem[14]=%h",
             mem[4], mem[5]);
    @(negedge clk);
    check("SW rst no late rsp", 32'(rsp_valid), 32'd0);

    do_req("LW 10 b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h22334411, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
